dvp_frame_gen: RTL and testbench

Synthetic OV7670-style DVP camera source: generates PCLK, VSYNC, HREF and RGB565 byte data for parameterisable frames. It sits on the transmit side of the camera bus and drives the microgreen capture path in loopback, bring-up and self-test without a physical sensor. Test patterns include a configurable "plant band" of green rows, which exercises the capture path's height and greenness features.

---
 rtl/dvp_gen_pkg.sv | 38 +++
 rtl/dvp_frame_gen_if.sv | 10 +
 rtl/dvp_pattern_rom.sv | 37 +++
 rtl/dvp_frame_gen.sv | 172 +++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dvp_gen_pkg.sv
// Shared types and constants for the synthetic DVP frame generator.
// Holds the FSM state encoding, pattern codes, fixed colours and the bar palette.
package dvp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_PLANT = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_RAMP  = 2'd3;

    localparam logic [15:0] SOIL_RGB  = 16'h8200;
    localparam logic [15:0] GREEN_RGB = 16'h07E0;

    // Index 0 is the rightmost element: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][15:0] BAR_PALETTE = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    typedef struct packed {
        logic [1:0]  pattern;
        logic [15:0] solid_rgb;
        logic [7:0]  plant_top;
        logic [7:0]  plant_bot;
    } frame_cfg_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_frame_gen_if.sv
// Transmit-side DVP camera bus: pixel clock, frame/line syncs and byte data.
interface dvp_frame_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] d;

    modport master (output pclk, vsync, href, d);
    modport slave  (input  pclk, vsync, href, d);
endinterface

// File: rtl/dvp_pattern_rom.sv
// Combinational test-pattern map: (latched config, row, byte index) -> pixel byte.
// RGB565 pixels are emitted high byte first.
module dvp_pattern_rom
    import dvp_gen_pkg::*;
#(
    parameter int ROW_W     = 2,
    parameter int BYTE_W    = 5,
    parameter int BAR_SHIFT = 0
) (
    input  frame_cfg_t        cfg,
    input  logic [ROW_W-1:0]  row,
    input  logic [BYTE_W-1:0] byte_idx,
    output logic [7:0]        d
);
    logic [2:0]  bar_idx;
    logic        in_band;
    logic [15:0] pixel;

    // Column is byte_idx >> 1, so the bar index folds that shift into BAR_SHIFT
    assign bar_idx = 3'(32'(byte_idx) >> (BAR_SHIFT + 1));
    assign in_band = (32'(row) >= 32'(cfg.plant_top)) && (32'(row) <= 32'(cfg.plant_bot));

    always_comb begin
        pixel = cfg.solid_rgb;
        case (cfg.pattern)
            PAT_SOLID: pixel = cfg.solid_rgb;
            PAT_PLANT: pixel = in_band ? GREEN_RGB : SOIL_RGB;
            PAT_BARS:  pixel = BAR_PALETTE[bar_idx];
            default:   pixel = cfg.solid_rgb;
        endcase
        if (cfg.pattern == PAT_RAMP) begin
            d = 8'(byte_idx);
        end else begin
            d = byte_idx[0] ? pixel[7:0] : pixel[15:8];
        end
    end
endmodule

// File: rtl/dvp_frame_gen.sv
// Synthetic OV7670-style DVP source generating PCLK/VSYNC/HREF and RGB565 test frames.
// Optional frame checksum adder is enabled by defining DVP_GEN_CHECKSUM_EN.
module dvp_frame_gen
    import dvp_gen_pkg::*;
#(
    parameter int H_ACTIVE    = 8,
    parameter int V_ACTIVE    = 4,
    parameter int H_BLANK     = 4,
    parameter int VSYNC_LINES = 1,
    parameter int V_BACK      = 1,
    parameter int V_FRONT     = 1,
    parameter int BAR_SHIFT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      pattern_sel,
    input  logic [15:0]     solid_rgb,
    input  logic [7:0]      plant_top,
    input  logic [7:0]      plant_bot,
    dvp_frame_gen_if.master bus,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     checksum
);
    localparam int ACT_BYTES  = 2 * H_ACTIVE;
    localparam int LINE_BYTES = ACT_BYTES + H_BLANK;
    localparam int MAX_LINES  = max_int(max_int(VSYNC_LINES, V_BACK), max_int(V_ACTIVE, V_FRONT));
    localparam int BYTE_W     = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    state_t            state_reg, state_next;
    logic [BYTE_W-1:0] byte_reg, byte_next;
    logic [LINE_W-1:0] line_reg, line_next;
    frame_cfg_t        cfg_reg;
    logic              phase_reg;
    logic              frame_done_reg;
    logic              tick, line_end, last_line, frame_end, entering_vsync;
    logic              vsync_c, href_c;
    logic [7:0]        rom_d, d_c;
    int                state_lines;

    // Every update happens on the edge where pclk falls, i.e. while phase is 1
    assign tick = phase_reg;

    always_comb begin
        state_lines = 1;
        case (state_reg)
            ST_VSYNC:  state_lines = VSYNC_LINES;
            ST_VBACK:  state_lines = V_BACK;
            ST_ACTIVE: state_lines = V_ACTIVE;
            ST_VFRONT: state_lines = V_FRONT;
            default:   state_lines = 1;
        endcase
    end

    assign line_end       = (int'(byte_reg) == LINE_BYTES - 1);
    assign last_line      = line_end && (int'(line_reg) == state_lines - 1);
    assign frame_end      = last_line && ((state_reg == ST_VFRONT) ||
                                          (state_reg == ST_ACTIVE && V_FRONT == 0));
    assign entering_vsync = (state_next == ST_VSYNC) && (state_reg != ST_VSYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (tick) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (en) state_next = ST_VSYNC;
            ST_VSYNC:  if (last_line) state_next = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_VBACK:  if (last_line) state_next = ST_ACTIVE;
            ST_ACTIVE: if (last_line) state_next = (V_FRONT > 0) ? ST_VFRONT :
                                                   (en ? ST_VSYNC : ST_IDLE);
            ST_VFRONT: if (last_line) state_next = en ? ST_VSYNC : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        vsync_c = (state_reg == ST_VSYNC);
        href_c  = (state_reg == ST_ACTIVE) && (int'(byte_reg) < ACT_BYTES);
        busy    = (state_reg != ST_IDLE);
    end

    // Byte and line counters restart whenever the FSM changes state
    always_comb begin
        byte_next = byte_reg;
        line_next = line_reg;
        if (state_next != state_reg || state_reg == ST_IDLE) begin
            byte_next = '0;
            line_next = '0;
        end else if (line_end) begin
            byte_next = '0;
            line_next = line_reg + 1'b1;
        end else begin
            byte_next = byte_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg      <= 1'b0;
            byte_reg       <= '0;
            line_reg       <= '0;
            cfg_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            phase_reg      <= ~phase_reg;
            frame_done_reg <= tick && frame_end;
            if (tick) begin
                byte_reg <= byte_next;
                line_reg <= line_next;
                if (entering_vsync) begin
                    cfg_reg.pattern   <= pattern_sel;
                    cfg_reg.solid_rgb <= solid_rgb;
                    cfg_reg.plant_top <= plant_top;
                    cfg_reg.plant_bot <= plant_bot;
                end
            end
        end
    end

    dvp_pattern_rom #(
        .ROW_W     (LINE_W),
        .BYTE_W    (BYTE_W),
        .BAR_SHIFT (BAR_SHIFT)
    ) u_rom (
        .cfg      (cfg_reg),
        .row      (line_reg),
        .byte_idx (byte_reg),
        .d        (rom_d)
    );

    assign d_c        = href_c ? rom_d : 8'h00;
    assign bus.pclk   = phase_reg;
    assign bus.vsync  = vsync_c;
    assign bus.href   = href_c;
    assign bus.d      = d_c;
    assign frame_done = frame_done_reg;

`ifdef DVP_GEN_CHECKSUM_EN
    logic [15:0] sum_reg;
    logic [15:0] checksum_reg;

    // The byte being driven during the closing byte time is folded in at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg      <= '0;
            checksum_reg <= '0;
        end else if (tick) begin
            if (frame_end) begin
                checksum_reg <= sum_reg + 16'(d_c);
            end
            if (entering_vsync) begin
                sum_reg <= '0;
            end else if (href_c) begin
                sum_reg <= sum_reg + 16'(d_c);
            end
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Randomized self-checking bench for dvp_frame_gen against a frame-level reference model.
// Each captured frame is compared byte-time by byte-time with the model's expected bus.
module tb_dvp_frame_gen;
    localparam int H_ACTIVE    = 8;
    localparam int V_ACTIVE    = 4;
    localparam int H_BLANK     = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int BAR_SHIFT   = 0;
    localparam int LINE_BYTES  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int FIRST_ACT   = VSYNC_LINES + V_BACK;

    typedef struct packed {
        logic [1:0]  pat;
        logic [15:0] solid;
        logic [7:0]  top;
        logic [7:0]  bot;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic [7:0]  plant_top = 8'd0;
    logic [7:0]  plant_bot = 8'd0;
    logic        busy;
    logic        frame_done;
    logic [15:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_count = 0;

    logic [15:0] palette [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_frame_gen_if bus();

    dvp_frame_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .BAR_SHIFT   (BAR_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .plant_top   (plant_top),
        .plant_bot   (plant_bot),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference pixel byte from the pattern rules
    function automatic logic [7:0] model_byte(input cfg_t c, input int row, input int b);
        logic [15:0] px;
        int col;
        col = b / 2;
        case (c.pat)
            2'd0:    px = c.solid;
            2'd1:    px = (row >= int'(c.top) && row <= int'(c.bot)) ? 16'h07E0 : 16'h8200;
            2'd2:    px = palette[(col >> BAR_SHIFT) % 8];
            default: px = 16'h0000;
        endcase
        if (c.pat == 2'd3) return 8'(b);
        return (b % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.pat   = 2'($urandom_range(0, 3));
        c.solid = 16'($urandom);
        c.top   = 8'($urandom_range(0, 5));
        c.bot   = 8'($urandom_range(0, 5));
        return c;
    endfunction

    task automatic apply(input cfg_t c, input logic en_val);
        pattern_sel = c.pat;
        solid_rgb   = c.solid;
        plant_top   = c.top;
        plant_bot   = c.bot;
        en          = en_val;
    endtask

    // Starts (or continues) a frame with config c, changes inputs to c_after and en to
    // en_after right after the first byte time, and checks the full frame.
    task automatic run_frame(input string name, input cfg_t c, input logic en_after, input cfg_t c_after);
        int waited;
        int fd0;
        logic [15:0] exp_sum;
        logic [15:0] exp_ck;
        logic vs, hr;
        logic [7:0] dd;
        apply(c, 1'b1);
        waited = 0;
        exp_sum = 16'h0000;
        while (!(bus.pclk === 1'b1 && bus.vsync === 1'b1) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({name, " vsync_start"}, 32'(bus.vsync), 32'd1);
        fd0 = fd_count;
        apply(c_after, en_after);
        for (int l = 0; l < FRAME_LINES; l++) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (!(l == 0 && b == 0)) begin
                    waited = 0;
                    do begin
                        @(negedge clk);
                        waited++;
                    end while (bus.pclk !== 1'b1 && waited < 4);
                end
                vs = (l < VSYNC_LINES);
                hr = (l >= FIRST_ACT) && (l < FIRST_ACT + V_ACTIVE) && (b < 2 * H_ACTIVE);
                dd = hr ? model_byte(c, l - FIRST_ACT, b) : 8'h00;
                if (hr) exp_sum = exp_sum + 16'(dd);
                check($sformatf("%s L%0d B%0d {vsync,href,d}", name, l, b),
                      {22'd0, bus.vsync, bus.href, bus.d}, {22'd0, vs, hr, dd});
            end
        end
`ifdef DVP_GEN_CHECKSUM_EN
        exp_ck = exp_sum;
`else
        exp_ck = 16'h0000;
`endif
        @(negedge clk);
        check({name, " frame_done"}, 32'(frame_done), 32'd1);
        check({name, " checksum"}, 32'(checksum), 32'(exp_ck));
        check({name, " busy_after"}, 32'(busy), 32'(en_after));
        check({name, " vsync_rerise"}, 32'(bus.vsync), 32'(en_after));
        @(negedge clk);
        check({name, " frame_done_width"}, 32'(frame_done), 32'd0);
        check({name, " frame_done_count"}, 32'(fd_count - fd0), 32'd1);
        $display("frame %s pat=%0d solid=%h top=%0d bot=%0d model_sum=%h checksum=%h",
                 name, c.pat, c.solid, c.top, c.bot, exp_sum, checksum);
    endtask

    initial begin
        cfg_t c, cn;
        int waited;

        // Reset held with en high: everything stays quiet
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold %0d", i),
                  {4'd0, bus.pclk, bus.vsync, bus.href, bus.d, busy, frame_done, checksum},
                  32'd0);
        end
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("pclk_period %0d", i), 32'(bus.pclk), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        c = '{pat: 2'd0, solid: 16'hF800, top: 8'd0, bot: 8'd0};
        run_frame("solid_F800", c, 1'b0, rand_cfg());
        repeat (20) @(negedge clk);
        check("idle_after_solid busy", 32'(busy), 32'd0);

        c = '{pat: 2'd1, solid: 16'h1234, top: 8'd1, bot: 8'd2};
        run_frame("plant_1_2", c, 1'b0, rand_cfg());
        c = '{pat: 2'd1, solid: 16'h1234, top: 8'd3, bot: 8'd1};
        run_frame("plant_3_1", c, 1'b0, rand_cfg());
        c = '{pat: 2'd3, solid: 16'h0000, top: 8'd0, bot: 8'd0};
        run_frame("ramp", c, 1'b0, rand_cfg());
        c = '{pat: 2'd2, solid: 16'h0000, top: 8'd0, bot: 8'd0};
        run_frame("bars", c, 1'b0, rand_cfg());

        // Back-to-back frames; each mid-frame change becomes the next frame's config
        c = rand_cfg();
        for (int k = 0; k < 6; k++) begin
            cn = rand_cfg();
            run_frame($sformatf("cont%0d", k), c, (k < 5) ? 1'b1 : 1'b0, cn);
            c = cn;
        end

        // Reset during the active region, then a clean restart
        repeat (10) @(negedge clk);
        apply(rand_cfg(), 1'b1);
        waited = 0;
        while (!(bus.pclk === 1'b1 && bus.href === 1'b1) && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid reached_active", 32'(bus.href), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid outputs",
              {4'd0, bus.pclk, bus.vsync, bus.href, bus.d, busy, frame_done, checksum}, 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid idle busy", 32'(busy), 32'd0);
        c = '{pat: 2'd1, solid: 16'h0000, top: 8'd0, bot: 8'd3};
        run_frame("after_reset", c, 1'b0, rand_cfg());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
